// File: rtl/xbus_pe_receiver_if.sv
// Bus bundle between the upstream X-bus driver and one PE receiver.
// The drop_count signal is present only when XBUS_RX_DROP_CNT_EN is defined.
interface xbus_pe_receiver_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int TW = $clog2(NUM_COL) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [TW-1:0]           X_ID;
  logic [TW-1:0]           X_TAG;
  logic                    flush;
  logic [DATA_WIDTH-1:0]   ifmap_data_G2B;
  logic [DATA_WIDTH-1:0]   fltr_data_G2B;
  logic [2*DATA_WIDTH-1:0] psum_data_G2B;
  logic [DATA_WIDTH-1:0]   ifmap_out;
  logic [DATA_WIDTH-1:0]   fltr_out;
  logic [2*DATA_WIDTH-1:0] psum_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic                    overflow;
  logic [1:0]              state;
`ifdef XBUS_RX_DROP_CNT_EN
  logic [15:0]             drop_count;
`endif

  modport master (
    output X_ID, X_TAG, flush, ifmap_data_G2B, fltr_data_G2B, psum_data_G2B, out_ready,
    input  ifmap_out, fltr_out, psum_out, out_valid, count, full, empty, overflow, state
`ifdef XBUS_RX_DROP_CNT_EN
    , input drop_count
`endif
  );

  modport slave (
    input  X_ID, X_TAG, flush, ifmap_data_G2B, fltr_data_G2B, psum_data_G2B, out_ready,
    output ifmap_out, fltr_out, psum_out, out_valid, count, full, empty, overflow, state
`ifdef XBUS_RX_DROP_CNT_EN
    , output drop_count
`endif
  );
endinterface

// File: rtl/xbus_pe_receiver.sv
// Tag-matched X-bus capture into a first-word-fall-through FIFO for one PE column.
// Optional XBUS_RX_DROP_CNT_EN adds a saturating 16-bit dropped-word counter.
module xbus_pe_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  xbus_pe_receiver_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 4 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, empty, push_req, push, pop, drop;
  logic [EW-1:0]   head;
`ifdef XBUS_RX_DROP_CNT_EN
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push_req = (state_q == ACTIVE) && bus.flush && (bus.X_TAG == bus.X_ID);
  assign pop      = !empty && bus.out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | drop;
    count_d    = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = {bus.ifmap_data_G2B, bus.fltr_data_G2B, bus.psum_data_G2B};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.flush) state_d = ACTIVE;
      ACTIVE:  if (!bus.flush) state_d = (count_d != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (bus.flush)            state_d = ACTIVE;
        else if (count_d == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef XBUS_RX_DROP_CNT_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) drop_cnt_d = sat_inc16(drop_cnt_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef XBUS_RX_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
`ifdef XBUS_RX_DROP_CNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.ifmap_out = head[EW-1 -: DATA_WIDTH];
  assign bus.fltr_out  = head[2*DATA_WIDTH +: DATA_WIDTH];
  assign bus.psum_out  = head[2*DATA_WIDTH-1:0];
  assign bus.out_valid = !empty;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;
  assign bus.state     = state_q;
`ifdef XBUS_RX_DROP_CNT_EN
  assign bus.drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_xbus_pe_receiver.sv
// Scoreboard bench for xbus_pe_receiver: stimulus queues expected words, a monitor checks pops.
module tb_xbus_pe_receiver;
  typedef struct packed {
    logic [15:0] i;
    logic [15:0] f;
    logic [31:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   pops_mark;
  exp_t sb[$];
  exp_t got;

  xbus_pe_receiver_if #(.DATA_WIDTH(16), .NUM_COL(4), .FIFO_DEPTH(4)) bus ();
  xbus_pe_receiver #(.DATA_WIDTH(16), .NUM_COL(4), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // One bus cycle; when cap is set the word is expected to enter the FIFO at this edge.
  task automatic cyc(input logic fl, input logic [2:0] tag, input logic [15:0] ifm,
                     input logic rdy, input logic cap);
    exp_t e;
    bus.flush          = fl;
    bus.X_TAG          = tag;
    bus.ifmap_data_G2B = ifm;
    bus.fltr_data_G2B  = ~ifm;
    bus.psum_data_G2B  = {ifm, 16'hA5A5};
    bus.out_ready      = rdy;
    if (cap) begin
      e.i = ifm; e.f = ~ifm; e.p = {ifm, 16'hA5A5};
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sb.delete();
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rstn && bus.out_valid && bus.out_ready) begin
      pops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got ifmap %0h expected no valid word", bus.ifmap_out);
      end else begin
        got = sb.pop_front();
        chk("pop_ifmap", 32'(bus.ifmap_out), 32'(got.i));
        chk("pop_fltr",  32'(bus.fltr_out),  32'(got.f));
        chk("pop_psum",  bus.psum_out,       got.p);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.X_ID = 3'd0;
    bus.X_TAG = 3'd0;
    bus.flush = 1'b0;
    bus.ifmap_data_G2B = '0;
    bus.fltr_data_G2B = '0;
    bus.psum_data_G2B = '0;
    bus.out_ready = 1'b0;
    rstn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_state",     32'(bus.state),     32'd0);
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_empty",     32'(bus.empty),     32'd1);
    chk("rst_full",      32'(bus.full),      32'd0);
    chk("rst_valid",     32'(bus.out_valid), 32'd0);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    chk("rst_ifmap_out", 32'(bus.ifmap_out), 32'd0);
    chk("rst_psum_out",  bus.psum_out,       32'd0);
`ifdef XBUS_RX_DROP_CNT_EN
    chk("rst_drop_count", 32'(bus.drop_count), 32'd0);
`endif
    rstn = 1'b1;

    // Matching tag while idle with flush low: nothing captured
    bus.X_ID = 3'd3;
    repeat (3) cyc(1'b0, 3'd3, 16'h0033, 1'b0, 1'b0);
    chk("idle_empty", 32'(bus.empty), 32'd1);
    chk("idle_state", 32'(bus.state), 32'd0);

    // Two tagged words in a six-cycle window, streamed out immediately
    bus.X_ID = 3'd2;
    pops_mark = pops;
    cyc(1'b1, 3'd2, 16'h00EE, 1'b1, 1'b0);
    chk("first_flush_nocap", 32'(bus.empty), 32'd1);
    chk("act_state", 32'(bus.state), 32'd1);
    cyc(1'b1, 3'd2, 16'h0011, 1'b1, 1'b1);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_count", 32'(bus.count), 32'd1);
    cyc(1'b1, 3'd0, 16'h0BAD, 1'b1, 1'b0);
    cyc(1'b1, 3'd2, 16'h0022, 1'b1, 1'b1);
    cyc(1'b1, 3'd0, 16'h0BAD, 1'b1, 1'b0);
    cyc(1'b1, 3'd0, 16'h0BAD, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("two_pops", 32'(pops - pops_mark), 32'd2);
    chk("win_idle", 32'(bus.state), 32'd0);

    // Overfill with out_ready low: last two words dropped
    bus.X_ID = 3'd1;
    cyc(1'b1, 3'd1, 16'h0100, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b1, 3'd1, 16'h0101 + 16'(k), 1'b0, k < 4);
    chk("ovf_count",    32'(bus.count),    32'd4);
    chk("ovf_full",     32'(bus.full),     32'd1);
    chk("ovf_overflow", 32'(bus.overflow), 32'd1);
`ifdef XBUS_RX_DROP_CNT_EN
    chk("ovf_drop_count", 32'(bus.drop_count), 32'd2);
`endif
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("ovf_drain_state", 32'(bus.state), 32'd2);
    repeat (4) cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("ovf_drained_state", 32'(bus.state),    32'd0);
    chk("ovf_sticky",        32'(bus.overflow), 32'd1);
    do_reset();
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Full FIFO with simultaneous push and pop
    cyc(1'b1, 3'd1, 16'h0200, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 3'd1, 16'h0201 + 16'(k), 1'b0, 1'b1);
    chk("pp_full_before", 32'(bus.full), 32'd1);
    cyc(1'b1, 3'd1, 16'h02AA, 1'b1, 1'b1);
    chk("pp_count",    32'(bus.count),    32'd4);
    chk("pp_overflow", 32'(bus.overflow), 32'd0);
    repeat (4) cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("pp_empty", 32'(bus.empty), 32'd1);
    chk("pp_state", 32'(bus.state), 32'd0);

    // Flush falls with three words held: drain then idle
    bus.X_ID = 3'd2;
    cyc(1'b1, 3'd2, 16'h0300, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 3'd2, 16'h0301 + 16'(k), 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("drain_state", 32'(bus.state), 32'd2);
    chk("drain_count", 32'(bus.count), 32'd3);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
      chk("drain_step_count", 32'(bus.count), 32'(2 - k));
      chk("drain_step_state", 32'(bus.state), (k == 2) ? 32'd0 : 32'd2);
    end

    // Reset while active with three entries held
    bus.X_ID = 3'd1;
    cyc(1'b1, 3'd1, 16'h0400, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 3'd1, 16'h0401 + 16'(k), 1'b0, 1'b1);
    chk("mid_count", 32'(bus.count), 32'd3);
    chk("mid_state", 32'(bus.state), 32'd1);
    rstn = 1'b0;
    sb.delete();
    cyc(1'b1, 3'd1, 16'h04FF, 1'b0, 1'b0);
    chk("mid_rst_state",    32'(bus.state),     32'd0);
    chk("mid_rst_count",    32'(bus.count),     32'd0);
    chk("mid_rst_valid",    32'(bus.out_valid), 32'd0);
    chk("mid_rst_overflow", 32'(bus.overflow),  32'd0);
    chk("mid_rst_ifmap",    32'(bus.ifmap_out), 32'd0);
    rstn = 1'b1;
    repeat (2) cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xbus_pe_receiver.md
XBUS_PE_RECEIVER -- requirements
Module: xbus_pe_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 16, shall set the width of the ifmap and filter words; the psum word shall be 2*DATA_WIDTH.
REQ-002 Parameter NUM_COL, default 4, shall set the tag/ID width to TW = $clog2(NUM_COL)+1.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >= 2, shall set the number of capture entries.
REQ-004 clk  in  1  single clock; all logic shall be on posedge clk.
REQ-005 rstn  in  1  reset, synchronous and active-low.
REQ-006 X_ID  in  TW  static column ID of this PE.
REQ-007 X_TAG  in  TW  bus tag produced by the upstream X-bus driver.
REQ-008 flush  in  1  capture window enable from upstream.
REQ-009 ifmap_data_G2B  in  DATA_WIDTH  bus ifmap word.
REQ-010 fltr_data_G2B  in  DATA_WIDTH  bus filter word.
REQ-011 psum_data_G2B  in  2*DATA_WIDTH  bus psum word.
REQ-012 ifmap_out, fltr_out, psum_out  out  DATA_WIDTH/DATA_WIDTH/2*DATA_WIDTH  head-of-FIFO triple.
REQ-013 out_valid  out  1  head triple valid; out_ready  in  1  PE accepts the head triple.
REQ-014 count  out  $clog2(FIFO_DEPTH)+1  current occupancy; full, empty  out  1 each.
REQ-015 overflow  out  1  sticky drop flag; state  out  2  FSM state (IDLE=0, ACTIVE=1, DRAIN=2).

Function
REQ-016 The FSM shall go IDLE->ACTIVE when flush=1.
REQ-017 The FSM shall go ACTIVE->DRAIN when flush=0 and count (after this cycle's update) >0, and ACTIVE->IDLE when flush=0 and count becomes 0.
REQ-018 The FSM shall go DRAIN->ACTIVE when flush=1, and DRAIN->IDLE when the FIFO becomes empty.
REQ-019 A push shall occur when state==ACTIVE, flush==1, and X_TAG==X_ID (full TW-bit compare), writing {ifmap, fltr, psum} as one entry.
REQ-020 No capture shall occur in IDLE or DRAIN, or in the first flush cycle seen in IDLE; the first capture shall be one cycle after the IDLE->ACTIVE transition.
REQ-021 A pop shall occur when out_valid && out_ready; the FIFO shall be first-word-fall-through with out_valid = !empty, and the outputs shall show the oldest entry combinationally from a registered array.
REQ-022 Latency shall be 1 cycle: a word captured at edge N shall be valid on the outputs after edge N.
REQ-023 A push when full shall be accepted only if a pop occurs in the same cycle; otherwise the word shall be dropped and overflow shall be set.
REQ-024 A simultaneous push and pop on a non-full FIFO shall leave count unchanged; a push and pop on an empty FIFO shall not bypass (the pop is invalid).
REQ-025 Read and write pointers shall wrap modulo FIFO_DEPTH; full shall be count==FIFO_DEPTH and empty shall be count==0.
REQ-026 overflow shall clear only on reset.

Reset
REQ-027 With rstn=0 at posedge clk: state=IDLE, pointers=0, count=0, empty=1, full=0, out_valid=0, overflow=0, and data outputs shall read 0 (the array is cleared).
REQ-028 Reset asserted mid-operation shall discard all entries at that edge, with no pop credited.

Configuration
REQ-029 With macro XBUS_RX_DROP_CNT_EN defined: an extra output drop_count (16 bits) shall count dropped words, saturating at 16'hFFFF, and reset to 0.
REQ-030 Without XBUS_RX_DROP_CNT_EN: the drop_count port and its counter shall be absent, and overflow behaviour shall be unchanged.

Verification
REQ-031 X_ID=2, flush=1 for 6 cycles, X_TAG=2 on cycles 2,4 with ifmap=16'h0011/16'h0022, out_ready=1 -> exactly two pops with ifmap_out 0x0011 then 0x0022.
REQ-032 X_ID=1, X_TAG=1 every ACTIVE cycle, out_ready=0, 6 matches -> count stops at 4, full=1, overflow=1, 2 words dropped, drop_count=2 when the macro is enabled.
REQ-033 FIFO full with push and pop in the same cycle -> count stays 4, overflow stays 0, and the new word is read back 4 pops later.
REQ-034 flush falls with 3 entries held -> state=DRAIN; pops with out_ready=1 give count 2,1,0, then state=IDLE.
REQ-035 rstn=0 for 1 cycle while count=3 in ACTIVE -> next cycle state=0, count=0, out_valid=0, overflow=0.
REQ-036 X_TAG=3 with X_ID=3 but flush=0 (IDLE) -> no capture and empty stays 1.
